// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel-X pipeline.
// Contents: pixel/gradient types, the column-feeder FSM state encoding,
// and a strip-count helper used to size the feeder's strip counter.
package sobel_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned GRAD_W = 10;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [GRAD_W-1:0] grad_t;

    typedef enum logic [1:0] {
        FILL_FIRST = 2'd0,
        FILL       = 2'd1,
        DRAIN      = 2'd2
    } feeder_state_t;

    // Strips needed to cover a frame when consecutive strips share 2 rows.
    function automatic int unsigned nstrips(input int unsigned height,
                                            input int unsigned size);
        return (height - 2) / (size - 2);
    endfunction

endpackage

// File: rtl/sobel_row_bank.sv
// One image row of pixel storage.
// Ports:
//   clk    - system clock, rising edge
//   we     - write enable
//   waddr  - write column address
//   wdata  - write pixel
//   raddr  - read column address (combinational read)
//   rdata  - pixel at raddr
module sobel_row_bank
    import sobel_pkg::*;
#(
    parameter int unsigned  IMG_WIDTH = 640,
    localparam int unsigned AW        = $clog2(IMG_WIDTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pixel_t        wdata,
    input  logic [AW-1:0] raddr,
    output pixel_t        rdata
);

    pixel_t mem [IMG_WIDTH];

    // Single write port; contents need no reset since every strip refills them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sobel_column_feeder.sv
// Buffers SIZE raster rows and replays them as one SIZE-pixel column per clock.
// Consecutive strips share 2 rows, so only SIZE-2 new rows are loaded per
// strip after the first; the row banks are used as a ring addressed via top.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   pix_in      - raster pixel, accepted when pix_valid && pix_ready
//   pix_valid   - pix_in valid
//   pix_ready   - combinational; high while filling
//   col_out     - column, element i = strip row i (0 topmost)
//   col_valid   - col_out valid
//   col_first   - column 0 of a strip
//   strip_last  - column belongs to the final strip of the frame
//   frame_done  - pulse with the last column of the frame
module sobel_column_feeder
    import sobel_pkg::*;
#(
    parameter int unsigned SIZE       = 3,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic   clk,
    input  logic   rst_n,
    input  pixel_t pix_in,
    input  logic   pix_valid,
    output logic   pix_ready,
    output pixel_t col_out [SIZE-1:0],
    output logic   col_valid,
    output logic   col_first,
    output logic   strip_last,
    output logic   frame_done
);

    localparam int unsigned NSTRIPS = nstrips(IMG_HEIGHT, SIZE);
    localparam int unsigned CW      = $clog2(IMG_WIDTH);
    localparam int unsigned RW      = $clog2(SIZE);
    localparam int unsigned RW1     = RW + 1;
    localparam int unsigned SW      = (NSTRIPS > 1) ? $clog2(NSTRIPS) : 1;

    // (a + b) mod SIZE for a, b < SIZE, as a conditional subtract.
    function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] a,
                                               input logic [RW-1:0] b);
        logic [RW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= RW1'(SIZE)) begin
            sum = sum - RW1'(SIZE);
        end
        return sum[RW-1:0];
    endfunction

    feeder_state_t state, state_next;
    logic [CW-1:0] pix_cnt, pix_cnt_next;
    logic [RW-1:0] row_cnt, row_cnt_next;
    logic [CW-1:0] col_cnt, col_cnt_next;
    logic [SW-1:0] strip_cnt, strip_cnt_next;
    logic [RW-1:0] top, top_next;
    logic [RW-1:0] last_row;
    logic [RW-1:0] wr_row;

    pixel_t col_out_next [SIZE-1:0];
    logic   col_valid_next;
    logic   col_first_next;
    logic   strip_last_next;
    logic   frame_done_next;

    logic [SIZE-1:0] bank_we;
    pixel_t          bank_rdata [SIZE-1:0];
    pixel_t          rot_col    [SIZE-1:0];
    logic            accept;

    assign pix_ready = (state != DRAIN);
    assign accept    = pix_valid && pix_ready;

    // Write steering into the ring and read rotation so row 0 is logical top.
    always_comb begin
        wr_row = wrap_add(top, row_cnt);
        for (int i = 0; i < SIZE; i++) begin
            bank_we[i] = accept && (wr_row == RW'(i));
            rot_col[i] = bank_rdata[wrap_add(top, RW'(i))];
        end
    end

    for (genvar g = 0; g < SIZE; g++) begin : g_bank
        sobel_row_bank #(
            .IMG_WIDTH(IMG_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .waddr (pix_cnt),
            .wdata (pix_in),
            .raddr (col_cnt),
            .rdata (bank_rdata[g])
        );
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_next      = state;
        pix_cnt_next    = pix_cnt;
        row_cnt_next    = row_cnt;
        col_cnt_next    = col_cnt;
        strip_cnt_next  = strip_cnt;
        top_next        = top;
        col_out_next    = col_out;
        col_valid_next  = 1'b0;
        col_first_next  = 1'b0;
        strip_last_next = 1'b0;
        frame_done_next = 1'b0;
        last_row        = (state == FILL_FIRST) ? RW'(SIZE - 1) : RW'(SIZE - 3);

        case (state)
            FILL_FIRST, FILL: begin
                if (accept) begin
                    if (pix_cnt == CW'(IMG_WIDTH - 1)) begin
                        pix_cnt_next = '0;
                        if (row_cnt == last_row) begin
                            row_cnt_next = '0;
                            col_cnt_next = '0;
                            state_next   = DRAIN;
                            if (state == FILL_FIRST) begin
                                strip_cnt_next = '0;
                            end else begin
                                // Oldest SIZE-2 rows were just replaced; advance the ring.
                                top_next = wrap_add(top, RW'(SIZE - 2));
                            end
                        end else begin
                            row_cnt_next = row_cnt + RW'(1);
                        end
                    end else begin
                        pix_cnt_next = pix_cnt + CW'(1);
                    end
                end
            end

            DRAIN: begin
                col_out_next    = rot_col;
                col_valid_next  = 1'b1;
                col_first_next  = (col_cnt == '0);
                strip_last_next = (strip_cnt == SW'(NSTRIPS - 1));
                if (col_cnt == CW'(IMG_WIDTH - 1)) begin
                    col_cnt_next = '0;
                    if (strip_cnt == SW'(NSTRIPS - 1)) begin
                        frame_done_next = 1'b1;
                        strip_cnt_next  = '0;
                        top_next        = '0;
                        state_next      = FILL_FIRST;
                    end else begin
                        strip_cnt_next = strip_cnt + SW'(1);
                        state_next     = FILL;
                    end
                end else begin
                    col_cnt_next = col_cnt + CW'(1);
                end
            end

            default: begin
                state_next = FILL_FIRST;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL_FIRST;
            pix_cnt    <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            strip_cnt  <= '0;
            top        <= '0;
            for (int i = 0; i < SIZE; i++) begin
                col_out[i] <= '0;
            end
            col_valid  <= 1'b0;
            col_first  <= 1'b0;
            strip_last <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            pix_cnt    <= pix_cnt_next;
            row_cnt    <= row_cnt_next;
            col_cnt    <= col_cnt_next;
            strip_cnt  <= strip_cnt_next;
            top        <= top_next;
            col_out    <= col_out_next;
            col_valid  <= col_valid_next;
            col_first  <= col_first_next;
            strip_last <= strip_last_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_sobel_column_feeder.sv
// Directed bench: A = SIZE 3, 4x5 frame (3 strips); B = SIZE 5, 4x8 frame (2 strips).
// Pixel value = row*16 + col.
module tb_sobel_column_feeder;

    logic       clk;
    logic       rst_n;
    logic [7:0] pin_a, pin_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic [7:0] col_a [2:0];
    logic [7:0] col_b [4:0];
    logic       cv_a, cf_a, sl_a, fd_a;
    logic       cv_b, cf_b, sl_b, fd_b;

    int checks = 0;
    int errors = 0;

    sobel_column_feeder #(.SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(5)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pin_a),
        .pix_valid  (valid_a),
        .pix_ready  (ready_a),
        .col_out    (col_a),
        .col_valid  (cv_a),
        .col_first  (cf_a),
        .strip_last (sl_a),
        .frame_done (fd_a)
    );

    sobel_column_feeder #(.SIZE(5), .IMG_WIDTH(4), .IMG_HEIGHT(8)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pin_b),
        .pix_valid  (valid_b),
        .pix_ready  (ready_b),
        .col_out    (col_b),
        .col_valid  (cv_b),
        .col_first  (cf_b),
        .strip_last (sl_b),
        .frame_done (fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one pixel and hold it for exactly one edge once ready is high.
    task automatic push(input bit sb, input logic [7:0] v);
        int n = 0;
        while (!(sb ? ready_b : ready_a) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
        if (sb) begin valid_b = 1'b1; pin_b = v; end
        else    begin valid_a = 1'b1; pin_a = v; end
        step();
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic push_rows(input bit sb, input int r0, input int nrows, input bit gaps);
        for (int r = r0; r < r0 + nrows; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) step();
                push(sb, 8'(r * 16 + c));
            end
        end
    endtask

    // Called right after the strip's last accepted pixel.
    task automatic drain(input bit sb, input int r0, input bit sl, input bit last,
                         input int ncols, input bit hold);
        int n;
        logic [7:0] obs;
        n = sb ? 5 : 3;
        check($sformatf("pre_valid_r%0d", r0), sb ? cv_b : cv_a, 32'd0);
        check($sformatf("pre_ready_r%0d", r0), sb ? ready_b : ready_a, 32'd0);
        if (hold) begin valid_a = 1'b1; pin_a = 8'hEE; end
        for (int c = 0; c < ncols; c++) begin
            step();
            check($sformatf("valid_r%0d_c%0d", r0, c), sb ? cv_b : cv_a, 32'd1);
            check($sformatf("first_r%0d_c%0d", r0, c), sb ? cf_b : cf_a, (c == 0) ? 32'd1 : 32'd0);
            check($sformatf("slast_r%0d_c%0d", r0, c), sb ? sl_b : sl_a, 32'(sl));
            check($sformatf("fdone_r%0d_c%0d", r0, c), sb ? fd_b : fd_a,
                  (last && c == 3) ? 32'd1 : 32'd0);
            if (c < 3) check($sformatf("ready_r%0d_c%0d", r0, c), sb ? ready_b : ready_a, 32'd0);
            for (int i = 0; i < n; i++) begin
                obs = sb ? col_b[i[2:0]] : col_a[i[1:0]];
                check($sformatf("col_r%0d_c%0d_e%0d", r0, c, i), obs, 32'((r0 + i) * 16 + c));
            end
        end
        valid_a = 1'b0;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_valid"}, cv_a, 32'd0);
        check({tag, "_first"}, cf_a, 32'd0);
        check({tag, "_slast"}, sl_a, 32'd0);
        check({tag, "_fdone"}, fd_a, 32'd0);
        check({tag, "_ready"}, ready_a, 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        pin_a   = 8'd0;
        pin_b   = 8'd0;
        step();
        step();

        // Reset state
        check_idle_a("rst");
        for (int i = 0; i < 3; i++) check($sformatf("rst_col_a%0d", i), col_a[i[1:0]], 32'd0);
        for (int i = 0; i < 5; i++) check($sformatf("rst_col_b%0d", i), col_b[i[2:0]], 32'd0);
        check("rst_ready_b", ready_b, 32'd1);
        check("rst_valid_b", cv_b, 32'd0);
        rst_n = 1'b1;

        // Frame 1: strip 1, strip 2 with pix_valid held through drain, strip 3 with gaps
        push_rows(1'b0, 0, 3, 1'b0);
        drain(1'b0, 0, 1'b0, 1'b0, 4, 1'b0);
        push_rows(1'b0, 3, 1, 1'b0);
        drain(1'b0, 1, 1'b0, 1'b0, 4, 1'b1);
        push_rows(1'b0, 4, 1, 1'b1);
        drain(1'b0, 2, 1'b1, 1'b1, 4, 1'b0);
        step();
        check_idle_a("post_frame");

        // Frame 2 back to back: 11 pixels must not release a column
        push_rows(1'b0, 0, 2, 1'b0);
        for (int c = 0; c < 3; c++) push(1'b0, 8'(32 + c));
        repeat (3) begin
            step();
            check("eleven_valid", cv_a, 32'd0);
            check("eleven_ready", ready_a, 32'd1);
        end
        push(1'b0, 8'd35);
        drain(1'b0, 0, 1'b0, 1'b0, 4, 1'b0);

        // Reset in the middle of strip 2 drain
        push_rows(1'b0, 3, 1, 1'b0);
        drain(1'b0, 1, 1'b0, 1'b0, 2, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle_a("midrst");
        for (int i = 0; i < 3; i++) check($sformatf("midrst_col%0d", i), col_a[i[1:0]], 32'd0);
        push_rows(1'b0, 0, 3, 1'b0);
        drain(1'b0, 0, 1'b0, 1'b0, 4, 1'b0);

        // SIZE=5: second strip loads 3 new rows
        push_rows(1'b1, 0, 5, 1'b0);
        drain(1'b1, 0, 1'b0, 1'b0, 4, 1'b0);
        push_rows(1'b1, 5, 3, 1'b1);
        drain(1'b1, 3, 1'b1, 1'b1, 4, 1'b0);
        step();
        check("b_post_valid", cv_b, 32'd0);
        check("b_post_fdone", fd_b, 32'd0);
        check("b_post_ready", ready_b, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
